// File: rtl/demux1t4_32_pkg.sv
// Shared constants and types for the 1:4 word demultiplexer.
// Channel ids double as the in_sel encoding.
package demux1t4_32_pkg;
   localparam int DATA_W = 32;
   localparam int N_CH = 4;
   localparam int FIFO_DEPTH = 2;
   typedef logic [1:0] chan_id_t;
endpackage

// File: rtl/demux1t4_32_if.sv
// Producer-side and consumer-side bundle of demux1t4_32.
// master = traffic generator / consumers, slave = the demux.
interface demux1t4_32_if #(
   parameter int WIDTH = demux1t4_32_pkg::DATA_W
);
   import demux1t4_32_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   chan_id_t         in_sel;
   logic [N_CH-1:0]  out_valid;
   logic [N_CH-1:0]  out_ready;
   logic [WIDTH-1:0] out_data0;
   logic [WIDTH-1:0] out_data1;
   logic [WIDTH-1:0] out_data2;
   logic [WIDTH-1:0] out_data3;
   logic [2*N_CH-1:0] lvl;

   modport master (
      output in_valid, in_data, in_sel, out_ready,
      input  in_ready, out_valid, lvl,
      input  out_data0, out_data1, out_data2, out_data3
   );

   modport slave (
      input  in_valid, in_data, in_sel, out_ready,
      output in_ready, out_valid, lvl,
      output out_data0, out_data1, out_data2, out_data3
   );
endinterface

// File: rtl/demux1t4_32_chan_fifo2.sv
// Two-entry channel FIFO with 1-bit pointers and a 2-bit count.
// No full-bypass: a push at full is refused even if the head pops.
module chan_fifo2
   import demux1t4_32_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             valid,
   output logic [1:0]       count,
   output logic [WIDTH-1:0] head
);
   logic [WIDTH-1:0] mem [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == 2'(DEPTH));
   assign valid   = (cnt != 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & valid;
   assign count   = cnt;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         unique case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 2'd1;
            2'b01:   cnt <= cnt - 2'd1;
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage is left unreset; valid gates every read.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/demux1t4_32.sv
// Routes one word per cycle to one of four buffered channels.
// in_ready only looks at the selected channel's fullness.
module demux1t4_32
   import demux1t4_32_pkg::*;
#(
   parameter int WIDTH = DATA_W,
   parameter int DEPTH = FIFO_DEPTH
) (
   input logic          clk,
   input logic          rstn,
   demux1t4_32_if.slave bus
);
   logic [N_CH-1:0]  full;
   logic [N_CH-1:0]  push;
   logic [N_CH-1:0]  valid;
   logic [1:0]       cnt  [N_CH];
   logic [WIDTH-1:0] head [N_CH];

   assign bus.in_ready = ~full[bus.in_sel];

   always_comb begin
      push = '0;
      for (int k = 0; k < N_CH; k++) begin
         push[k] = bus.in_valid & bus.in_ready &
                   (bus.in_sel == chan_id_t'(k));
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      chan_fifo2 #(
         .WIDTH (WIDTH),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rstn  (rstn),
         .push  (push[k]),
         .pop   (bus.out_ready[k]),
         .wdata (bus.in_data),
         .full  (full[k]),
         .valid (valid[k]),
         .count (cnt[k]),
         .head  (head[k])
      );
   end

   assign bus.out_valid = valid;
   assign bus.lvl       = {cnt[3], cnt[2], cnt[1], cnt[0]};
   assign bus.out_data0 = head[0];
   assign bus.out_data1 = head[1];
   assign bus.out_data2 = head[2];
   assign bus.out_data3 = head[3];
endmodule
